// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared definitions for the register-file writeback arbiter: default widths,
// register count and the buffered write-request record.
package regfile_wb_arbiter_pkg;

  localparam int AW_DEF    = 4;
  localparam int DW_DEF    = 32;
  localparam int REG_COUNT = 16;

  typedef struct packed {
    logic [AW_DEF-1:0] addr;
    logic [DW_DEF-1:0] data;
  } wr_req_t;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Bus bundle between the writeback requesters / decode stage (master) and the
// arbiter (slave): two request channels, the register-file write port and hazard lookups.
interface regfile_wb_arbiter_if #(
  parameter int AW = regfile_wb_arbiter_pkg::AW_DEF,
  parameter int DW = regfile_wb_arbiter_pkg::DW_DEF
) ();
  import regfile_wb_arbiter_pkg::*;

  logic                 a_valid;
  logic [AW-1:0]        a_addr;
  logic [DW-1:0]        a_data;
  logic                 a_ready;
  logic                 b_valid;
  logic [AW-1:0]        b_addr;
  logic [DW-1:0]        b_data;
  logic                 b_ready;
  logic                 RegWr;
  logic [AW-1:0]        Waddr;
  logic [DW-1:0]        Writedata;
  logic [AW-1:0]        Raddr1;
  logic [AW-1:0]        Raddr2;
  logic                 hazard1;
  logic                 hazard2;
  logic [REG_COUNT-1:0] busy;

  modport master (
    output a_valid, a_addr, a_data, input a_ready,
    output b_valid, b_addr, b_data, input b_ready,
    input  RegWr, Waddr, Writedata,
    output Raddr1, Raddr2,
    input  hazard1, hazard2, busy
  );

  modport slave (
    input  a_valid, a_addr, a_data, output a_ready,
    input  b_valid, b_addr, b_data, output b_ready,
    output RegWr, Waddr, Writedata,
    input  Raddr1, Raddr2,
    output hazard1, hazard2, busy
  );
endinterface

// File: rtl/regfile_wb_arbiter_wb_slot.sv
// One-entry writeback holding buffer. It can accept a new write in the same
// cycle its current content is granted, so a lone requester streams at full rate.
module wb_slot #(
  parameter int AW = 4,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          valid,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] data,
  input  logic          grant,
  output logic          full,
  output logic          ready,
  output logic [AW-1:0] q_addr,
  output logic [DW-1:0] q_data
);

  logic          full_q, full_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] data_q, data_d;
  logic          ready_s;
  logic          take_s;

  always_comb begin
    ready_s = ~full_q | grant;
    take_s  = valid & ready_s;
    full_d  = full_q;
    addr_d  = addr_q;
    data_d  = data_q;
    if (take_s) begin
      full_d = 1'b1;
      addr_d = addr;
      data_d = data;
    end else if (grant) begin
      full_d = 1'b0;
    end else begin
      full_d = full_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end

  assign full   = full_q;
  assign ready  = ready_s;
  assign q_addr = addr_q;
  assign q_data = data_q;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Oldest-first arbiter sharing the register-file write port between the ALU (A)
// and load (B) writeback buffers, with a pending-write scoreboard. Define
// RFARB_PERF_EN to add the perf_writes / perf_conflicts counters.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic                 CLK,
  input  logic                 RESET,
  regfile_wb_arbiter_if.slave  bus
`ifdef RFARB_PERF_EN
  ,
  output logic [31:0]          perf_writes,
  output logic [31:0]          perf_conflicts
`endif
);

  logic          a_full, b_full;
  logic [AW-1:0] a_buf_addr, b_buf_addr;
  logic [DW-1:0] a_buf_data, b_buf_data;
  logic          grant_a, grant_b, grant_any;
  logic          a_stays, b_stays, a_next, b_next;
  logic          age_q, age_d;
  logic          regwr_q, regwr_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [REG_COUNT-1:0] busy_s;

  wb_slot #(.AW(AW), .DW(DW)) u_slot_a (
    .clk(CLK), .rst(RESET), .valid(bus.a_valid), .addr(bus.a_addr), .data(bus.a_data),
    .grant(grant_a), .full(a_full), .ready(bus.a_ready), .q_addr(a_buf_addr), .q_data(a_buf_data)
  );

  wb_slot #(.AW(AW), .DW(DW)) u_slot_b (
    .clk(CLK), .rst(RESET), .valid(bus.b_valid), .addr(bus.b_addr), .data(bus.b_data),
    .grant(grant_b), .full(b_full), .ready(bus.b_ready), .q_addr(b_buf_addr), .q_data(b_buf_data)
  );

  // age_q = 1 means B holds the older write; a buffer that stays full is older than a fresh fill
  always_comb begin
    grant_a   = a_full & (~b_full | ~age_q);
    grant_b   = b_full & (~a_full | age_q);
    grant_any = grant_a | grant_b;
    a_stays   = a_full & ~grant_a;
    b_stays   = b_full & ~grant_b;
    a_next    = a_stays | (bus.a_valid & bus.a_ready);
    b_next    = b_stays | (bus.b_valid & bus.b_ready);
    age_d     = age_q;
    if (a_next && b_next) begin
      if (a_stays && !b_stays) begin
        age_d = 1'b0;
      end else if (b_stays && !a_stays) begin
        age_d = 1'b1;
      end else if (!a_stays && !b_stays) begin
        age_d = 1'b0;
      end else begin
        age_d = age_q;
      end
    end else begin
      age_d = age_q;
    end
  end

  always_comb begin
    regwr_d = grant_any;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    case ({grant_a, grant_b})
      2'b10: begin
        waddr_d = a_buf_addr;
        wdata_d = a_buf_data;
      end
      2'b01: begin
        waddr_d = b_buf_addr;
        wdata_d = b_buf_data;
      end
      default: begin
        waddr_d = waddr_q;
        wdata_d = wdata_q;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      age_q   <= 1'b0;
      regwr_q <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      age_q   <= age_d;
      regwr_q <= regwr_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  // A register stays busy from buffer capture through the end of its RegWr cycle
  always_comb begin
    busy_s = '0;
    for (int i = 0; i < REG_COUNT; i++) begin
      busy_s[i] = (a_full  && (a_buf_addr == AW'(i))) ||
                  (b_full  && (b_buf_addr == AW'(i))) ||
                  (regwr_q && (waddr_q    == AW'(i)));
    end
  end

  assign bus.busy      = busy_s;
  assign bus.hazard1   = busy_s[bus.Raddr1];
  assign bus.hazard2   = busy_s[bus.Raddr2];
  assign bus.RegWr     = regwr_q;
  assign bus.Waddr     = waddr_q;
  assign bus.Writedata = wdata_q;

`ifdef RFARB_PERF_EN
  logic [31:0] perf_writes_q, perf_writes_d;
  logic [31:0] perf_conflicts_q, perf_conflicts_d;

  always_comb begin
    perf_writes_d    = regwr_q ? (perf_writes_q + 32'd1) : perf_writes_q;
    perf_conflicts_d = (a_full && b_full) ? (perf_conflicts_q + 32'd1) : perf_conflicts_q;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      perf_writes_q    <= 32'd0;
      perf_conflicts_q <= 32'd0;
    end else begin
      perf_writes_q    <= perf_writes_d;
      perf_conflicts_q <= perf_conflicts_d;
    end
  end

  assign perf_writes    = perf_writes_q;
  assign perf_conflicts = perf_conflicts_q;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter with a negedge-committing
// register-file model.
module tb_regfile_wb_arbiter;

  logic CLK;
  logic RESET;
  int   n_cmp;
  int   n_err;
  logic [31:0] rf [16];

  regfile_wb_arbiter_if #(.AW(4), .DW(32)) bus ();

`ifdef RFARB_PERF_EN
  logic [31:0] perf_writes, perf_conflicts;
`endif

  regfile_wb_arbiter dut (
    .CLK(CLK),
    .RESET(RESET),
    .bus(bus)
`ifdef RFARB_PERF_EN
    ,
    .perf_writes(perf_writes),
    .perf_conflicts(perf_conflicts)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (bus.RegWr === 1'b1) rf[bus.Waddr] <= bus.Writedata;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    RESET = 1'b1;
    bus.a_valid = 1'b0; bus.a_addr = 4'd0; bus.a_data = 32'd0;
    bus.b_valid = 1'b0; bus.b_addr = 4'd0; bus.b_data = 32'd0;
    bus.Raddr1 = 4'd0;  bus.Raddr2 = 4'd0;
    repeat (3) @(posedge CLK);
    #1 RESET = 1'b0;

    check("rst_regwr", bus.RegWr, 32'd0);
    check("rst_waddr", bus.Waddr, 32'd0);
    check("rst_wdata", bus.Writedata, 32'd0);
    check("rst_busy", bus.busy, 32'd0);
    check("rst_haz1", bus.hazard1, 32'd0);
    check("rst_a_rdy", bus.a_ready, 32'd1);
    check("rst_b_rdy", bus.b_ready, 32'd1);

    // single writer
    bus.a_valid = 1'b1; bus.a_addr = 4'd3; bus.a_data = 32'h1234;
    tick();
    bus.a_valid = 1'b0;
    check("single_regwr0", bus.RegWr, 32'd0);
    check("single_busy_buf", bus.busy, 32'h0008);
    tick();
    check("single_regwr", bus.RegWr, 32'd1);
    check("single_waddr", bus.Waddr, 32'd3);
    check("single_wdata", bus.Writedata, 32'h1234);
    check("single_busy_wr", bus.busy, 32'h0008);
    tick();
    check("single_idle", bus.RegWr, 32'd0);
    check("single_busy_clr", bus.busy, 32'd0);

    // simultaneous fill: A wins, B presents again and is held off one cycle
    bus.a_valid = 1'b1; bus.a_addr = 4'd5; bus.a_data = 32'hAA;
    bus.b_valid = 1'b1; bus.b_addr = 4'd6; bus.b_data = 32'hBB;
    tick();
    bus.a_valid = 1'b0;
    bus.b_data = 32'hCC;
    check("simul_b_rdy0", bus.b_ready, 32'd0);
    check("simul_a_rdy", bus.a_ready, 32'd1);
    tick();
    check("simul_wr_a", bus.Waddr, 32'd5);
    check("simul_wd_a", bus.Writedata, 32'hAA);
    check("simul_b_rdy1", bus.b_ready, 32'd1);
    tick();
    bus.b_valid = 1'b0;
    check("simul_wr_b", bus.Waddr, 32'd6);
    check("simul_wd_b", bus.Writedata, 32'hBB);
    tick();
    check("simul_wd_b2", bus.Writedata, 32'hCC);
    check("simul_regwr_b2", bus.RegWr, 32'd1);
    tick();
    check("simul_idle", bus.RegWr, 32'd0);

    // same-address ordering with age alternation
    bus.a_valid = 1'b1; bus.a_addr = 4'd10; bus.a_data = 32'h10;
    bus.b_valid = 1'b1; bus.b_addr = 4'd12; bus.b_data = 32'h12;
    tick();
    bus.a_addr = 4'd11; bus.a_data = 32'h11;
    bus.b_valid = 1'b0;
    tick();
    check("ord_w10", bus.Waddr, 32'd10);
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b1; bus.b_addr = 4'd7; bus.b_data = 32'h1;
    check("ord_b_rdy", bus.b_ready, 32'd1);
    check("ord_a_rdy0", bus.a_ready, 32'd0);
    tick();
    check("ord_w12", bus.Waddr, 32'd12);
    bus.b_valid = 1'b0;
    bus.a_valid = 1'b1; bus.a_addr = 4'd7; bus.a_data = 32'h2;
    check("ord_a_rdy", bus.a_ready, 32'd1);
    check("ord_b_blk", bus.b_ready, 32'd0);
    tick();
    bus.a_valid = 1'b0;
    check("ord_w11", bus.Waddr, 32'd11);
    check("ord_busy7", bus.busy[7], 32'd1);
    tick();
    check("ord_first_a", bus.Waddr, 32'd7);
    check("ord_first_d", bus.Writedata, 32'h1);
    tick();
    check("ord_second_d", bus.Writedata, 32'h2);
    check("ord_busy7_wr", bus.busy[7], 32'd1);
    tick();
    check("ord_idle", bus.RegWr, 32'd0);
    check("ord_busy7_clr", bus.busy[7], 32'd0);
    check("ord_rf7", rf[7], 32'h2);

    // hazard lookup
    bus.a_valid = 1'b1; bus.a_addr = 4'd9; bus.a_data = 32'h99;
    bus.Raddr1 = 4'd9;  bus.Raddr2 = 4'd4;
    tick();
    bus.a_valid = 1'b0;
    check("haz1_buf", bus.hazard1, 32'd1);
    check("haz2_buf", bus.hazard2, 32'd0);
    tick();
    check("haz1_wr", bus.hazard1, 32'd1);
    tick();
    check("haz1_clr", bus.hazard1, 32'd0);

    // reset mid-operation: in-flight RegWr and a buffered write are both dropped
    bus.a_valid = 1'b1; bus.a_addr = 4'd2; bus.a_data = 32'h22;
    tick();
    bus.a_addr = 4'd3; bus.a_data = 32'h33;
    tick();
    bus.a_valid = 1'b0;
    check("mrst_inflight", bus.RegWr, 32'd1);
    #2 RESET = 1'b1;
    #1;
    check("mrst_regwr", bus.RegWr, 32'd0);
    check("mrst_busy", bus.busy, 32'd0);
    @(negedge CLK);
    RESET = 1'b0;
    tick();
    check("mrst_a_rdy", bus.a_ready, 32'd1);
    check("mrst_b_rdy", bus.b_ready, 32'd1);
    check("mrst_dropped", bus.RegWr, 32'd0);
    check("mrst_busy_post", bus.busy, 32'd0);

    // back-to-back streaming from A alone
    bus.a_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bus.a_addr = 4'(i);
      bus.a_data = 32'h100 + 32'(i);
      check("stream_rdy", bus.a_ready, 32'd1);
      tick();
      if (i > 0) begin
        check("stream_wr", bus.RegWr, 32'd1);
        check("stream_addr", bus.Waddr, 32'(i - 1));
      end
    end
    bus.a_valid = 1'b0;
    tick();
    check("stream_last_wr", bus.RegWr, 32'd1);
    check("stream_last_d", bus.Writedata, 32'h10F);
    tick();
    check("stream_idle", bus.RegWr, 32'd0);
    check("stream_rf15", rf[15], 32'h10F);
`ifdef RFARB_PERF_EN
    check("perf_writes", perf_writes, 32'd16);
    check("perf_conflicts", perf_conflicts, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
